wb_rr_arbiter: RTL
==================

Name: wb_rr_arbiter

Overview:
- Parametrised N-master to 1-slave Wishbone B4 pipelined arbiter.
- Lets any number of L1 request ports (L1I, L1D, future prefetch/DMA) share the single external Wishbone bus.
- Round-robin grant with whole-cycle ownership and outstanding-transfer tracking; replaces the fixed two-port internal arbitration of the L1 top.

Parameters:
NUM_M, 2, number of masters (>=2)
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8); SEL_W = DATA_W/8
MAX_OUTST, 4, max accepted-but-unacknowledged strobes per cycle (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
m_cyc_i  in  NUM_M  per-master cycle
m_stb_i  in  NUM_M  per-master strobe
m_we_i  in  NUM_M  per-master write enable
m_adr_i  in  NUM_M*ADDR_W  packed addresses, master k at [k*ADDR_W +: ADDR_W]
m_dat_i  in  NUM_M*DATA_W  packed write data
m_sel_i  in  NUM_M*SEL_W  packed byte selects
m_dat_o  out  DATA_W  read data, broadcast (s_dat_i)
m_ack_o  out  NUM_M  per-master ack
m_err_o  out  NUM_M  per-master err
m_stall_o  out  NUM_M  per-master stall
s_cyc_o, s_stb_o, s_we_o  out  1 each  slave controls
s_adr_o  out  ADDR_W;  s_dat_o  out  DATA_W;  s_sel_o  out  SEL_W
s_dat_i  in  DATA_W;  s_ack_i, s_err_i, s_stall_i  in  1 each
gnt_o  out  NUM_M  one-hot current owner (0 when idle)

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE, gnt_o=0, outst=0, rr_ptr=NUM_M-1 (master 0 highest priority first). Outputs while in reset/IDLE: s_cyc_o=s_stb_o=0, m_ack_o=m_err_o=0, m_stall_o=all 1; s_we_o/adr/dat/sel=0.
- States: IDLE, OWN.
- IDLE: if any m_cyc_i, winner = first k with m_cyc_i[k] searching rr_ptr+1, rr_ptr+2, ... mod NUM_M; register gnt_o=onehot(winner), go OWN. Grant latency: 1 cycle from cyc assertion to s_cyc_o.
- OWN (owner o): s_cyc_o=m_cyc_i[o]; s_we/adr/dat/sel from master o (combinational mux). s_stb_o = m_stb_i[o] & (outst<MAX_OUTST). m_stall_o[o] = s_stall_i | (outst==MAX_OUTST); all non-owners stalled, never acked.
- m_ack_o[o]=s_ack_i, m_err_o[o]=s_err_i; others 0. m_dat_o=s_dat_i always.
- Accept = s_stb_o & ~s_stall_i; Resp = s_ack_i | s_err_i. outst: +1 on Accept only, -1 on Resp only, unchanged on both. outst width ceil(log2(MAX_OUTST+1)); Resp with outst==0 ignored (no underflow).
- Release: m_cyc_i[o]=0 in OWN -> s_cyc_o drops same cycle; next edge: rr_ptr=o, gnt_o=0, outst=0, IDLE. Drop with outst>0 is an abort: counter cleared, no further responses routed.
- No back-to-back grant without an IDLE cycle (1 dead cycle between owners).
- Masters never preempted; fairness comes only from release plus rotation.
- Reset mid-OWN: next edge all state to reset values; s_cyc_o low from the same edge.
- err treated like ack for counting; the arbiter never asserts err itself.

Test Plan:
- Reset then m_cyc_i=01, one read stb adr 0x100 -> gnt_o=01 after 1 cycle, s_adr_o=0x100, s_dat_i=0xDEADBEEF with ack -> m_ack_o=01, m_dat_o=0xDEADBEEF.
- m_cyc_i=11 same cycle from reset -> master 0 owns first; after it drops cyc, 1 IDLE cycle, gnt_o=10; repeat with both held -> grants alternate 01,10,01.
- Owner issues 6 pipelined stbs, slave never acks, MAX_OUTST=4 -> 4 Accepts, then s_stb_o=0 and m_stall_o[o]=1; one ack -> 5th stb accepted.
- Accept and ack in same cycle at outst=2 -> outst stays 2; s_stall_i=1 during stb -> no Accept, outst unchanged.
- s_err_i pulse on 2nd transfer -> m_err_o[o]=1, m_ack_o[o]=0, outst decrements; non-owner m_err_o stays 0.
- rst_n=0 while OWN with outst=3 -> next cycle s_cyc_o=0, gnt_o=0, all stalls 1; next request granted to master 0.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave Wishbone B4 pipelined arbiter with round-robin grant,
// whole-cycle bus ownership and outstanding-strobe tracking.
module wb_rr_arbiter #(
    parameter int NUM_M     = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_M-1:0]            m_cyc_i,
    input  logic [NUM_M-1:0]            m_stb_i,
    input  logic [NUM_M-1:0]            m_we_i,
    input  logic [NUM_M*ADDR_W-1:0]     m_adr_i,
    input  logic [NUM_M*DATA_W-1:0]     m_dat_i,
    input  logic [NUM_M*(DATA_W/8)-1:0] m_sel_i,
    output logic [DATA_W-1:0]           m_dat_o,
    output logic [NUM_M-1:0]            m_ack_o,
    output logic [NUM_M-1:0]            m_err_o,
    output logic [NUM_M-1:0]            m_stall_o,
    output logic                        s_cyc_o,
    output logic                        s_stb_o,
    output logic                        s_we_o,
    output logic [ADDR_W-1:0]           s_adr_o,
    output logic [DATA_W-1:0]           s_dat_o,
    output logic [DATA_W/8-1:0]         s_sel_o,
    input  logic [DATA_W-1:0]           s_dat_i,
    input  logic                        s_ack_i,
    input  logic                        s_err_i,
    input  logic                        s_stall_i,
    output logic [NUM_M-1:0]            gnt_o
);

    localparam int SEL_W = DATA_W / 8;
    localparam int OUT_W = $clog2(MAX_OUTST + 1);
    localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_OWN
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] rr_ptr;
    logic [OUT_W-1:0] outst;

    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] cand;
    logic             found;
    logic             outst_full;
    logic             accept;
    logic             resp;
    logic             owner_cyc;

    // Round-robin search: start just after the last owner and take the first requester.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int i = 1; i <= NUM_M; i++) begin
            cand = IDX_W'((int'(rr_ptr) + i) % NUM_M);
            if (!found && m_cyc_i[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign outst_full = (outst == OUT_W'(MAX_OUTST));
    assign owner_cyc  = m_cyc_i[owner];
    assign accept     = s_stb_o & ~s_stall_i;
    assign resp       = s_ack_i | s_err_i;
    assign m_dat_o    = s_dat_i;

    // Slave-side mux and per-master response routing; everything idles when no owner.
    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        m_ack_o   = '0;
        m_err_o   = '0;
        m_stall_o = '1;
        if (state == ST_OWN) begin
            for (int k = 0; k < NUM_M; k++) begin
                if (owner == IDX_W'(k)) begin
                    s_cyc_o      = m_cyc_i[k];
                    s_stb_o      = m_stb_i[k] & ~outst_full;
                    s_we_o       = m_we_i[k];
                    s_adr_o      = m_adr_i[k*ADDR_W +: ADDR_W];
                    s_dat_o      = m_dat_i[k*DATA_W +: DATA_W];
                    s_sel_o      = m_sel_i[k*SEL_W +: SEL_W];
                    m_stall_o[k] = s_stall_i | outst_full;
                    m_ack_o[k]   = s_ack_i;
                    m_err_o[k]   = s_err_i;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            gnt_o  <= '0;
            owner  <= '0;
            rr_ptr <= IDX_W'(NUM_M - 1);
            outst  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|m_cyc_i) begin
                        gnt_o <= {{(NUM_M-1){1'b0}}, 1'b1} << winner;
                        owner <= winner;
                        state <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (!owner_cyc) begin
                        // Release (or abort): responses still in flight are dropped.
                        rr_ptr <= owner;
                        gnt_o  <= '0;
                        outst  <= '0;
                        state  <= ST_IDLE;
                    end else if (accept && !resp) begin
                        outst <= outst + OUT_W'(1);
                    end else if (resp && !accept && (outst != '0)) begin
                        outst <= outst - OUT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
